// File: rtl/serializer_arbiter.sv
// Round-robin arbiter that feeds one parallel word at a time into a shared
// shift serializer and tags the resulting beat stream with the owner's ID.
`ifndef SHIFT_FROM
`define SHIFT_FROM 32
`endif
`ifndef SHIFT_TO
`define SHIFT_TO 8
`endif

module serializer_arbiter_slot #(
  parameter int FROM = 32
) (
  input  logic            sel,
  input  logic            accept,
  input  logic [FROM-1:0] data,
  output logic            ready,
  output logic [FROM-1:0] data_sel
);
  assign ready    = sel & accept;
  assign data_sel = sel ? data : '0;
endmodule

module serializer_arbiter #(
  parameter int N_REQ = 4,
  parameter int LOG2N = 2,
  parameter int FROM  = `SHIFT_FROM,
  parameter int TO    = `SHIFT_TO
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ*FROM-1:0] req_data_i,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  output logic [FROM-1:0]       ser_data_o,
  output logic                  ser_valid_o,
  input  logic                  ser_ready_i,
  input  logic                  ser_sval_i,
  output logic [LOG2N-1:0]      stream_id_o,
  output logic                  stream_id_valid_o,
  output logic                  busy_o,
  output logic                  err_o
);

  if (TO < 1 || FROM % TO != 0) begin : g_bad_width
    $error("serializer_arbiter: FROM must be a positive multiple of TO");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                        state, state_nxt;
  logic [LOG2N-1:0]              rr_ptr, grant, grant_nxt;
  logic                          first_drain;
  logic                          any_req, accept, issuing, set_err;
  logic [N_REQ-1:0][FROM-1:0]    req_words;
  logic [N_REQ-1:0][FROM-1:0]    slot_data;

  assign req_words = req_data_i;

  // First valid requester strictly after rr_ptr, wrapping.
  always_comb begin : rr_search
    int               idx;
    logic [LOG2N-1:0] cand;
    grant_nxt = grant;
    any_req   = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = LOG2N'(idx);
      if (!any_req && req_valid_i[cand]) begin
        any_req   = 1'b1;
        grant_nxt = cand;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    issuing     = 1'b0;
    set_err     = 1'b0;
    ser_valid_o = 1'b0;
    case (state)
      IDLE: if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        issuing = 1'b1;
        // A withdrawn word is never offered, so the serializer cannot load it.
        if (!req_valid_i[grant]) begin
          set_err   = 1'b1;
          state_nxt = IDLE;
        end else begin
          ser_valid_o = 1'b1;
          // ready with sval high is the last-shift cycle: no load happens there.
          if (ser_ready_i && !ser_sval_i) begin
            accept    = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: if (!ser_sval_i) begin
        state_nxt = IDLE;
        set_err   = first_drain;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar r = 0; r < N_REQ; r++) begin : g_slot
    serializer_arbiter_slot #(.FROM(FROM)) u_slot (
      .sel      (issuing && (grant == LOG2N'(r))),
      .accept   (accept),
      .data     (req_words[r]),
      .ready    (req_ready_o[r]),
      .data_sel (slot_data[r])
    );
  end

  always_comb begin
    ser_data_o = '0;
    for (int r = 0; r < N_REQ; r++) ser_data_o = ser_data_o | slot_data[r];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= LOG2N'(N_REQ - 1);
      grant       <= '0;
      stream_id_o <= '0;
      first_drain <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_nxt;
      first_drain <= accept;
      if (state == IDLE && any_req) grant <= grant_nxt;
      if (accept) begin
        stream_id_o <= grant;
        rr_ptr      <= grant;
      end
      if (set_err) err_o <= 1'b1;
    end
  end

  assign stream_id_valid_o = (state == DRAIN) && ser_sval_i;
  assign busy_o            = (state != IDLE);

endmodule
